punc_control: RTL

PUNC_CONTROL -- requirements
Module: punc_control

---
 rtl/punc_control_if.sv | 40 ++++
 rtl/punc_control.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control_if.sv
// Control/datapath bundle for punc_control: instruction and condition codes in,
// datapath steering and write strobes out.
interface punc_control_if;
    logic [15:0] ir;
    logic        n;
    logic        z;
    logic        p;
    logic        ir_ld;
    logic        pc_ld;
    logic [1:0]  pc_sel;
    logic [1:0]  mem_addr_sel;
    logic        mdr_ld;
    logic        mem_w_en;
    logic [2:0]  rf_raddr0;
    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_waddr;
    logic        rf_w_en;
    logic [1:0]  rf_wsel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_op;
    logic [15:0] imm;
    logic        cc_ld;
    logic        halted;
    logic [2:0]  state;

    modport master (
        input  ir, n, z, p,
        output ir_ld, pc_ld, pc_sel, mem_addr_sel, mdr_ld, mem_w_en,
               rf_raddr0, rf_raddr1, rf_waddr, rf_w_en, rf_wsel,
               alu_a_sel, alu_b_sel, alu_op, imm, cc_ld, halted, state
    );

    modport slave (
        output ir, n, z, p,
        input  ir_ld, pc_ld, pc_sel, mem_addr_sel, mdr_ld, mem_w_en,
               rf_raddr0, rf_raddr1, rf_waddr, rf_w_en, rf_wsel,
               alu_a_sel, alu_b_sel, alu_op, imm, cc_ld, halted, state
    );
endinterface

// File: rtl/punc_control.sv
// Multi-cycle control FSM for the PUnC LC-3 style datapath. Only the state is
// registered; every control output is decoded from state, ir and n/z/p.
module punc_control (
    input  logic           clk,
    input  logic           rst,
    punc_control_if.master bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StExec2  = 3'd3,
        StHalt   = 3'd4
    } state_e;

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpLd   = 4'b0010;
    localparam logic [3:0] OpSt   = 4'b0011;
    localparam logic [3:0] OpJsr  = 4'b0100;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpLdr  = 4'b0110;
    localparam logic [3:0] OpStr  = 4'b0111;
    localparam logic [3:0] OpRsv8 = 4'b1000;
    localparam logic [3:0] OpNot  = 4'b1001;
    localparam logic [3:0] OpLdi  = 4'b1010;
    localparam logic [3:0] OpSti  = 4'b1011;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpRsvD = 4'b1101;
    localparam logic [3:0] OpLea  = 4'b1110;
    localparam logic [3:0] OpTrap = 4'b1111;

    localparam logic [1:0] PcInc = 2'd0;
    localparam logic [1:0] PcAlu = 2'd1;
    localparam logic [1:0] PcRf  = 2'd2;

    localparam logic [1:0] AddrPc  = 2'd0;
    localparam logic [1:0] AddrAlu = 2'd1;
    localparam logic [1:0] AddrMdr = 2'd2;

    localparam logic [1:0] WselAlu = 2'd0;
    localparam logic [1:0] WselMem = 2'd1;
    localparam logic [1:0] WselPc  = 2'd2;

    localparam logic [1:0] AluAdd = 2'd0;
    localparam logic [1:0] AluAnd = 2'd1;
    localparam logic [1:0] AluNot = 2'd3;

    localparam logic [7:0] HaltVector = 8'h25;

    state_e state_q, state_d;

    logic [3:0]  opcode;
    logic        br_taken;
    logic        is_halt_trap;
    logic [15:0] imm5;
    logic [15:0] imm6;
    logic [15:0] imm9;
    logic [15:0] imm11;

    assign opcode       = bus.ir[15:12];
    assign br_taken     = (bus.ir[11] & bus.n) | (bus.ir[10] & bus.z) | (bus.ir[9] & bus.p);
    assign is_halt_trap = (opcode == OpTrap) && (bus.ir[7:0] == HaltVector);
    assign imm5         = {{11{bus.ir[4]}}, bus.ir[4:0]};
    assign imm6         = {{10{bus.ir[5]}}, bus.ir[5:0]};
    assign imm9         = {{7{bus.ir[8]}}, bus.ir[8:0]};
    assign imm11        = {{5{bus.ir[10]}}, bus.ir[10:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = ((opcode == OpRsv8) || (opcode == OpRsvD)) ? StFetch : StExec;
            StExec: begin
                if ((opcode == OpLdi) || (opcode == OpSti)) begin
                    state_d = StExec2;
                end else if (is_halt_trap) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StExec2:  state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        bus.ir_ld        = 1'b0;
        bus.pc_ld        = 1'b0;
        bus.pc_sel       = PcInc;
        bus.mem_addr_sel = AddrPc;
        bus.mdr_ld       = 1'b0;
        bus.mem_w_en     = 1'b0;
        bus.rf_raddr0    = 3'd0;
        bus.rf_raddr1    = 3'd0;
        bus.rf_waddr     = 3'd0;
        bus.rf_w_en      = 1'b0;
        bus.rf_wsel      = WselAlu;
        bus.alu_a_sel    = 1'b0;
        bus.alu_b_sel    = 1'b0;
        bus.alu_op       = AluAdd;
        bus.imm          = 16'd0;
        bus.cc_ld        = 1'b0;
        bus.state        = state_q;
        bus.halted       = (state_q == StHalt);

        unique case (state_q)
            StFetch: begin
                bus.mem_addr_sel = AddrPc;
                bus.ir_ld        = 1'b1;
                bus.pc_ld        = 1'b1;
                bus.pc_sel       = PcInc;
            end
            StExec: begin
                unique case (opcode)
                    OpAdd, OpAnd: begin
                        bus.rf_raddr0 = bus.ir[8:6];
                        bus.rf_raddr1 = bus.ir[2:0];
                        bus.alu_a_sel = 1'b1;
                        bus.alu_b_sel = ~bus.ir[5];
                        bus.imm       = imm5;
                        bus.alu_op    = (opcode == OpAnd) ? AluAnd : AluAdd;
                        bus.rf_waddr  = bus.ir[11:9];
                        bus.rf_wsel   = WselAlu;
                        bus.rf_w_en   = 1'b1;
                        bus.cc_ld     = 1'b1;
                    end
                    OpNot: begin
                        bus.rf_raddr0 = bus.ir[8:6];
                        bus.alu_a_sel = 1'b1;
                        bus.alu_op    = AluNot;
                        bus.rf_waddr  = bus.ir[11:9];
                        bus.rf_wsel   = WselAlu;
                        bus.rf_w_en   = 1'b1;
                        bus.cc_ld     = 1'b1;
                    end
                    OpBr: begin
                        if (br_taken) begin
                            bus.pc_ld  = 1'b1;
                            bus.pc_sel = PcAlu;
                            bus.imm    = imm9;
                            bus.alu_op = AluAdd;
                        end
                    end
                    OpJmp: begin
                        bus.pc_ld     = 1'b1;
                        bus.pc_sel    = PcRf;
                        bus.rf_raddr0 = bus.ir[8:6];
                    end
                    OpJsr: begin
                        // PC already holds the return address after FETCH, so R7 gets it directly.
                        bus.rf_waddr = 3'd7;
                        bus.rf_wsel  = WselPc;
                        bus.rf_w_en  = 1'b1;
                        bus.pc_ld    = 1'b1;
                        if (bus.ir[11]) begin
                            bus.pc_sel = PcAlu;
                            bus.imm    = imm11;
                            bus.alu_op = AluAdd;
                        end else begin
                            bus.pc_sel    = PcRf;
                            bus.rf_raddr0 = bus.ir[8:6];
                        end
                    end
                    OpLd, OpLea: begin
                        bus.imm      = imm9;
                        bus.alu_op   = AluAdd;
                        bus.rf_waddr = bus.ir[11:9];
                        bus.rf_w_en  = 1'b1;
                        bus.cc_ld    = 1'b1;
                        if (opcode == OpLd) begin
                            bus.mem_addr_sel = AddrAlu;
                            bus.rf_wsel      = WselMem;
                        end
                    end
                    OpLdr: begin
                        bus.rf_raddr0    = bus.ir[8:6];
                        bus.alu_a_sel    = 1'b1;
                        bus.imm          = imm6;
                        bus.alu_op       = AluAdd;
                        bus.mem_addr_sel = AddrAlu;
                        bus.rf_wsel      = WselMem;
                        bus.rf_waddr     = bus.ir[11:9];
                        bus.rf_w_en      = 1'b1;
                        bus.cc_ld        = 1'b1;
                    end
                    OpSt: begin
                        bus.imm          = imm9;
                        bus.alu_op       = AluAdd;
                        bus.mem_addr_sel = AddrAlu;
                        bus.rf_raddr1    = bus.ir[11:9];
                        bus.mem_w_en     = 1'b1;
                    end
                    OpStr: begin
                        bus.rf_raddr0    = bus.ir[8:6];
                        bus.alu_a_sel    = 1'b1;
                        bus.imm          = imm6;
                        bus.alu_op       = AluAdd;
                        bus.mem_addr_sel = AddrAlu;
                        bus.rf_raddr1    = bus.ir[11:9];
                        bus.mem_w_en     = 1'b1;
                    end
                    OpLdi, OpSti: begin
                        // First hop fetches the pointer into MDR; EXEC2 uses it as the address.
                        bus.imm          = imm9;
                        bus.alu_op       = AluAdd;
                        bus.mem_addr_sel = AddrAlu;
                        bus.mdr_ld       = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            StExec2: begin
                if (opcode == OpLdi) begin
                    bus.mem_addr_sel = AddrMdr;
                    bus.rf_waddr     = bus.ir[11:9];
                    bus.rf_wsel      = WselMem;
                    bus.rf_w_en      = 1'b1;
                    bus.cc_ld        = 1'b1;
                end else if (opcode == OpSti) begin
                    bus.mem_addr_sel = AddrMdr;
                    bus.rf_raddr1    = bus.ir[11:9];
                    bus.mem_w_en     = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Reset masks every write strobe so an abandoned instruction leaves no trace.
        if (!rst) begin
            bus.ir_ld    = 1'b0;
            bus.pc_ld    = 1'b0;
            bus.mdr_ld   = 1'b0;
            bus.mem_w_en = 1'b0;
            bus.rf_w_en  = 1'b0;
            bus.cc_ld    = 1'b0;
        end
    end

endmodule
